// File: rtl/lsu_dccm_req_seq_if.sv
// LSU request/response and DCCM port bundle for lsu_dccm_req_seq.
// The sequencer connects through the master modport; LSU and memory models use slave.
interface lsu_dccm_req_seq_if #(
    parameter int DCCM_BITS  = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  lsu_freeze_dc3;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DCCM_BITS-1:0]  req_addr;
    logic [1:0]            req_size;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  dccm_rden;
    logic                  dccm_wren;
    logic [DCCM_BITS-1:0]  dccm_rd_addr_lo;
    logic [DCCM_BITS-1:0]  dccm_rd_addr_hi;
    logic [DCCM_BITS-1:0]  dccm_wr_addr;
    logic [DATA_WIDTH-1:0] dccm_wr_data;
    logic [DATA_WIDTH-1:0] dccm_rd_data_lo;
    logic [DATA_WIDTH-1:0] dccm_rd_data_hi;

    modport master (
        input  lsu_freeze_dc3, req_valid, req_write, req_addr, req_size, req_wdata,
        input  dccm_rd_data_lo, dccm_rd_data_hi,
        output req_ready, rsp_valid, rsp_rdata,
        output dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi,
        output dccm_wr_addr, dccm_wr_data
    );

    modport slave (
        output lsu_freeze_dc3, req_valid, req_write, req_addr, req_size, req_wdata,
        output dccm_rd_data_lo, dccm_rd_data_hi,
        input  req_ready, rsp_valid, rsp_rdata,
        input  dccm_rden, dccm_wren, dccm_rd_addr_lo, dccm_rd_addr_hi,
        input  dccm_wr_addr, dccm_wr_data
    );
endinterface

// File: rtl/lsu_dccm_req_seq.sv
// LSU-side DCCM sequencer: loads as lo/hi read pairs, sub-word/misaligned stores as read-modify-write.
// Optional `LSU_DCCM_WR_FWD_EN: 1-entry last-written-word register lets aligned RMW stores skip the read.
module lsu_dccm_req_seq #(
    parameter int DCCM_BITS  = 16,
    parameter int DATA_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    lsu_dccm_req_seq_if.master bus
);
    localparam int W  = DATA_WIDTH;
    localparam int WB = DCCM_BITS - 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WR_LO = 3'd2;
    localparam logic [2:0] S_WR_HI = 3'd3;
    localparam logic [2:0] S_RSP   = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;

    // Word index of the last byte touched; carries out of the word wrap modulo the DCCM size.
    function automatic logic [WB-1:0] last_word(input logic [DCCM_BITS-1:0] a, input logic [1:0] sz);
        logic [2:0] span;
        span = (sz == 2'd0) ? 3'd0 : (sz == 2'd1) ? 3'd1 : 3'd3;
        return a[DCCM_BITS-1:2] + {{(WB-1){1'b0}}, (({1'b0, a[1:0]} + span) > 3'd3)};
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        return (sz == 2'd0) ? 4'b0001 : (sz == 2'd1) ? 4'b0011 : 4'b1111;
    endfunction

    logic [2:0]           state, state_nxt;
    logic                 q_write;
    logic [DCCM_BITS-1:0] q_addr;
    logic [1:0]           q_size;
    logic [W-1:0]         q_wdata;
    logic [W-1:0]         hi_merge;

    logic                 active, accept, req_rmw;
    logic [WB-1:0]        q_lo_word, q_hi_word, wr_word;
    logic                 q_mis;
    logic [4:0]           sh;
    logic [7:0]           byte_sel;
    logic [2*W-1:0]       lane_mask, ins_data, old_pair, merged;
    logic [W-1:0]         load_mask;
    logic                 skip_rd;

`ifdef LSU_DCCM_WR_FWD_EN
    logic                 fwd_valid;
    logic [WB-1:0]        fwd_word;
    logic [W-1:0]         fwd_data;
    logic                 q_fwd;
`endif

    assign active        = ~bus.lsu_freeze_dc3;
    assign bus.req_ready = (state == S_IDLE) & active;
    assign accept        = bus.req_valid & bus.req_ready;
    assign req_rmw       = bus.req_write & (~bus.req_size[1] | (bus.req_addr[1:0] != 2'b00));

    assign q_lo_word = q_addr[DCCM_BITS-1:2];
    assign q_hi_word = last_word(q_addr, q_size);
    assign q_mis     = (q_lo_word != q_hi_word);
    assign sh        = {q_addr[1:0], 3'b000};

`ifdef LSU_DCCM_WR_FWD_EN
    assign skip_rd = fwd_valid
                   & (fwd_word == bus.req_addr[DCCM_BITS-1:2])
                   & (last_word(bus.req_addr, bus.req_size) == bus.req_addr[DCCM_BITS-1:2]);
`else
    assign skip_rd = 1'b0;
`endif

    always_comb begin
        byte_sel  = {4'b0000, size_mask(q_size)} << q_addr[1:0];
        lane_mask = '0;
        load_mask = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            lane_mask[i*8 +: 8] = {8{byte_sel[i]}};
        end
        for (int unsigned i = 0; i < 4; i++) begin
            load_mask[i*8 +: 8] = {8{size_mask(q_size)[i]}};
        end
        ins_data = {{W{1'b0}}, q_wdata} << sh;
`ifdef LSU_DCCM_WR_FWD_EN
        old_pair = q_fwd ? {fwd_data, fwd_data} : {bus.dccm_rd_data_hi, bus.dccm_rd_data_lo};
`else
        old_pair = {bus.dccm_rd_data_hi, bus.dccm_rd_data_lo};
`endif
        merged = (old_pair & ~lane_mask) | (ins_data & lane_mask);
    end

    always_comb begin
        state_nxt = state;
        if (active) begin
            case (state)
                S_IDLE:  if (accept) state_nxt = (!bus.req_write || (req_rmw && !skip_rd)) ? S_RD : S_WR_LO;
                S_RD:    state_nxt = q_write ? S_WR_LO : S_RSP;
                S_WR_LO: state_nxt = q_mis ? S_WR_HI : S_ACK;
                S_WR_HI: state_nxt = S_ACK;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            q_write  <= 1'b0;
            q_addr   <= '0;
            q_size   <= '0;
            q_wdata  <= '0;
            hi_merge <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                q_write <= bus.req_write;
                q_addr  <= bus.req_addr;
                q_size  <= bus.req_size;
                q_wdata <= bus.req_wdata;
            end
            // Read data for the hi word is gone once WR_LO retires, so keep the merged copy.
            if (state == S_WR_LO && active) begin
                hi_merge <= merged[2*W-1:W];
            end
        end
    end

`ifdef LSU_DCCM_WR_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_word  <= '0;
            fwd_data  <= '0;
            q_fwd     <= 1'b0;
        end else begin
            if (bus.dccm_wren) begin
                fwd_valid <= 1'b1;
                fwd_word  <= wr_word;
                fwd_data  <= bus.dccm_wr_data;
            end
            if (accept) begin
                q_fwd <= req_rmw & skip_rd;
            end
        end
    end
`endif

    assign wr_word = (state == S_WR_HI) ? q_hi_word : q_lo_word;

    assign bus.dccm_rden       = (state == S_RD) & active;
    assign bus.dccm_wren       = ((state == S_WR_LO) | (state == S_WR_HI)) & active;
    assign bus.rsp_valid       = ((state == S_RSP) | (state == S_ACK)) & active;
    assign bus.dccm_rd_addr_lo = {q_lo_word, 2'b00};
    assign bus.dccm_rd_addr_hi = {q_hi_word, 2'b00};
    assign bus.dccm_wr_addr    = {wr_word, 2'b00};
    assign bus.dccm_wr_data    = (state == S_WR_LO) ? merged[W-1:0] :
                                 (state == S_WR_HI) ? hi_merge : '0;
    assign bus.rsp_rdata       = (state == S_RSP)
                               ? (W'({bus.dccm_rd_data_hi, bus.dccm_rd_data_lo} >> sh) & load_mask)
                               : '0;
endmodule
